// File: rtl/playfield_render_pkg.sv
`default_nettype none
//==============================================================================
// Module   : playfield_render_pkg
// Purpose  : Shared colours, visible-area limits and frame-state encoding.
// Revision : 1.0 - initial release
//==============================================================================
package playfield_render_pkg;

    localparam logic [11:0] c_border = 12'hFFF;
    localparam logic [11:0] c_grid   = 12'h222;
    localparam logic [11:0] c_flash  = 12'h00F;
    localparam logic [11:0] c_black  = 12'h000;

    localparam int c_h_visible = 640;
    localparam int c_v_visible = 480;

    typedef enum logic [0:0] {
        ST_SCAN   = 1'b0,
        ST_VBLANK = 1'b1
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/pix_delay_line.sv
`default_nettype none
//==============================================================================
// Module   : pix_delay_line
// Purpose  : Pixel-enable gated shift register of configurable depth and width.
// Revision : 1.0 - initial release
//==============================================================================
module pix_delay_line #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
        end else if (i_ce) begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/playfield_render.sv
`default_nettype none
//==============================================================================
// Module   : playfield_render
// Purpose  : Two-stage pixel pipeline drawing the playfield, piece, border,
//            grid and game-over flash from the VGA scan position.
// Revision : 1.0 - initial release
//==============================================================================
module playfield_render
    import playfield_render_pkg::*;
#(
    parameter int CELL_PX  = 16,
    parameter int ORIGIN_X = 240,
    parameter int ORIGIN_Y = 80,
    parameter int COLS     = 10,
    parameter int ROWS     = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [3:0]  cell_x,
    output logic [4:0]  cell_y,
    input  logic [11:0] cell_color,
    input  logic [3:0]  x1,
    input  logic [3:0]  x2,
    input  logic [3:0]  x3,
    input  logic [3:0]  x4,
    input  logic [4:0]  y1,
    input  logic [4:0]  y2,
    input  logic [4:0]  y3,
    input  logic [4:0]  y4,
    input  logic [11:0] piece_color,
    input  logic        game_over,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_done
);

    localparam int         c_shift   = $clog2(CELL_PX);
    localparam logic [9:0] c_field_w = 10'(COLS * CELL_PX);
    localparam logic [9:0] c_field_h = 10'(ROWS * CELL_PX);

    logic [9:0]   w_rel_x, w_rel_y;
    logic         w_in_field, w_border, w_grid;
    logic [3:0]   w_flags_a;
    logic [1:0]   w_sync_b;
    logic         w_piece_hit, w_flash, w_frame_start, w_frame_end;
    logic [11:0]  w_rgb_next;
    frame_state_t r_state, w_state_next;

    logic [3:0]  r_cell_x;
    logic [4:0]  r_cell_y;
    logic [11:0] r_rgb;
    logic        r_frame_done;
    logic [4:0]  r_frame_cnt;
    logic [3:0]  r_px [4];
    logic [4:0]  r_py [4];
    logic [11:0] r_pcolor;

    // Wrapped offsets make one unsigned compare cover both field edges; all-ones is the ring just before the origin.
    assign w_rel_x    = hcount - 10'(ORIGIN_X);
    assign w_rel_y    = vcount - 10'(ORIGIN_Y);
    assign w_in_field = (w_rel_x < c_field_w) && (w_rel_y < c_field_h);
    assign w_border   = ((w_rel_x <= c_field_w) || (w_rel_x == '1)) &&
                        ((w_rel_y <= c_field_h) || (w_rel_y == '1)) && !w_in_field;
    assign w_grid     = (w_rel_x[c_shift-1:0] == '0) || (w_rel_y[c_shift-1:0] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cell_x <= '0;
            r_cell_y <= '0;
        end else if (pix_ce) begin
            r_cell_x <= w_in_field ? w_rel_x[c_shift +: 4] : 4'd0;
            r_cell_y <= w_in_field ? w_rel_y[c_shift +: 5] : 5'd0;
        end
    end

    pix_delay_line #(.DEPTH(1), .WIDTH(4), .RESET_VAL(4'b0000)) u_flag_dly (
        .clk    (clk),
        .reset  (reset),
        .i_ce   (pix_ce),
        .i_din  ({video_on, w_in_field, w_border, w_grid}),
        .o_dout (w_flags_a)
    );

    pix_delay_line #(.DEPTH(2), .WIDTH(2), .RESET_VAL(2'b11)) u_sync_dly (
        .clk    (clk),
        .reset  (reset),
        .i_ce   (pix_ce),
        .i_din  ({hsync_in, vsync_in}),
        .o_dout (w_sync_b)
    );

    assign w_frame_start = pix_ce && (hcount == '0) && (vcount == '0);

    // Piece is sampled only at frame start so a move never tears mid-frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_px[i] <= 4'd0;
                r_py[i] <= 5'd31;
            end
            r_pcolor <= '0;
        end else if (w_frame_start) begin
            r_px[0] <= x1;  r_px[1] <= x2;  r_px[2] <= x3;  r_px[3] <= x4;
            r_py[0] <= y1;  r_py[1] <= y2;  r_py[2] <= y3;  r_py[3] <= y4;
            r_pcolor <= piece_color;
        end
    end

    always_comb begin
        w_piece_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((r_px[i] == r_cell_x) && (r_py[i] == r_cell_y) && (int'(r_py[i]) < ROWS))
                w_piece_hit = 1'b1;
        end
    end

    assign w_flash = game_over && r_frame_cnt[4];

    always_comb begin
        w_rgb_next = c_black;
        if (!w_flags_a[3])           w_rgb_next = c_black;
        else if (w_flags_a[1])       w_rgb_next = c_border;
        else if (!w_flags_a[2])      w_rgb_next = c_black;
        else if (w_flash)            w_rgb_next = c_flash;
        else if (w_piece_hit)        w_rgb_next = r_pcolor;
        else if (cell_color != '0)   w_rgb_next = cell_color;
        else if (w_flags_a[0])       w_rgb_next = c_grid;
        else                         w_rgb_next = c_black;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_rgb <= '0;
        else if (pix_ce) r_rgb <= w_rgb_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (pix_ce && (hcount == '0) && (vcount == 10'(c_v_visible))) begin
                    w_state_next = ST_VBLANK;
                    w_frame_end  = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (w_frame_start) w_state_next = ST_SCAN;
            end
            default: w_state_next = ST_VBLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_VBLANK;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_frame_end;
            if (w_frame_end) r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    assign cell_x     = r_cell_x;
    assign cell_y     = r_cell_y;
    assign rgb        = r_rgb;
    assign hsync_out  = w_sync_b[1];
    assign vsync_out  = w_sync_b[0];
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
